// File: rtl/ds_pkg.sv
// Shared sizes, fill FSM encoding and tree pseudo-LRU helpers for the cache data store controller.
package ds_pkg;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WAYS   = 4;
  localparam int unsigned SETS   = 4;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_COLL = 2'd1,
    F_PEND = 2'd2
  } fill_st_e;

  // Bits {b2,b1,b0} point at the victim: b0 picks the pair, b1/b2 pick within it.
  function automatic logic [WAYS-1:0] plru_victim(input logic [2:0] bits);
    if (!bits[0]) return bits[1] ? 4'b0010 : 4'b0001;
    else          return bits[2] ? 4'b1000 : 4'b0100;
  endfunction

  function automatic logic [2:0] plru_update(input logic [2:0] bits, input logic [WAYS-1:0] way);
    logic [2:0] nxt;
    nxt = bits;
    case (way)
      4'b0001: begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
      4'b0010: begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
      4'b0100: begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
      4'b1000: begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
      default: ;
    endcase
    return nxt;
  endfunction
endpackage

// File: rtl/ds_plru.sv
// Per-set tree pseudo-LRU state with one update port and one victim lookup port.
module ds_plru
  import ds_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [WAYS-1:0]  upd_way,
  input  logic [IDX_W-1:0] vic_index,
  output logic [WAYS-1:0]  vic_way
);
  logic [2:0] r_bits [SETS];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < SETS; i++) r_bits[i] <= 3'b000;
    end else if (upd && |upd_way) begin
      r_bits[upd_index] <= plru_update(r_bits[upd_index], upd_way);
    end
  end

  assign vic_way = plru_victim(r_bits[vic_index]);
endmodule

// File: rtl/ds_ctrl.sv
// Data store sequencer: fill line assembly, fill/store/load arbitration with load anti-starvation,
// and the registered load response.
module ds_ctrl
  import ds_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld_req,
  input  logic [IDX_W-1:0]  ld_index,
  input  logic [WAYS-1:0]   ld_way,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [LINE_W-1:0] ld_rdata,
  input  logic              st_req,
  input  logic [IDX_W-1:0]  st_index,
  input  logic [WAYS-1:0]   st_way,
  input  logic [LINE_W-1:0] st_data,
  input  logic [LINE_W-1:0] st_mask,
  output logic              st_gnt,
  input  logic              fl_valid,
  input  logic [IDX_W-1:0]  fl_index,
  input  logic [BEAT_W-1:0] fl_data,
  output logic              fl_ready,
  output logic              fl_done,
  output logic [WAYS-1:0]   fl_way,
  output logic              ds_valid,
  output logic [IDX_W-1:0]  ds_index,
  output logic [WAYS-1:0]   ds_way,
  output logic [LINE_W-1:0] ds_data_in,
  output logic [LINE_W-1:0] ds_mask_in,
  output logic              ds_w,
  input  logic [LINE_W-1:0] ds_cache_line
);
  localparam int unsigned SW = $clog2(STARVE_MAX + 2);

  fill_st_e          r_state;
  logic [1:0]        r_beat;
  logic [LINE_W-1:0] r_line;
  logic [IDX_W-1:0]  r_fl_index;
  logic              r_fl_done;
  logic [WAYS-1:0]   r_fl_way;
  logic [SW-1:0]     r_starve;
  logic              r_ld_rvalid;
  logic [LINE_W-1:0] r_ld_rdata;

  logic              w_fill_win;
  logic              w_ld_prio;
  logic [WAYS-1:0]   w_vic;

  assign w_fill_win = (r_state == F_PEND);
  assign w_ld_prio  = (r_starve >= SW'(STARVE_MAX));
  assign ld_gnt     = !w_fill_win && ld_req && (w_ld_prio || !st_req);
  assign st_gnt     = !w_fill_win && st_req && !ld_gnt;
  assign fl_ready   = (r_state != F_PEND);
  assign fl_done    = r_fl_done;
  assign fl_way     = r_fl_way;
  assign ld_rvalid  = r_ld_rvalid;
  assign ld_rdata   = r_ld_rdata;

  always_comb begin
    ds_valid   = 1'b0;
    ds_w       = 1'b0;
    ds_index   = '0;
    ds_way     = '0;
    ds_data_in = '0;
    ds_mask_in = '0;
    if (w_fill_win) begin
      ds_valid   = 1'b1;
      ds_w       = 1'b1;
      ds_index   = r_fl_index;
      ds_way     = w_vic;
      ds_data_in = r_line;
      ds_mask_in = '1;
    end else if (st_gnt) begin
      // A store miss is still granted so the requester retires it, but writes nothing.
      ds_valid   = 1'b1;
      ds_w       = |st_way;
      ds_index   = st_index;
      ds_way     = st_way;
      ds_data_in = st_data;
      ds_mask_in = st_mask;
    end else if (ld_gnt) begin
      ds_valid   = 1'b1;
      ds_index   = ld_index;
      ds_way     = ld_way;
    end
  end

  ds_plru u_plru (
    .clk       (clk),
    .clr       (clr),
    .upd       (ds_valid),
    .upd_index (ds_index),
    .upd_way   (ds_way),
    .vic_index (r_fl_index),
    .vic_way   (w_vic)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= F_IDLE;
      r_beat     <= 2'd0;
      r_line     <= '0;
      r_fl_index <= '0;
      r_fl_done  <= 1'b0;
      r_fl_way   <= '0;
    end else begin
      r_fl_done <= 1'b0;
      case (r_state)
        F_IDLE: begin
          if (fl_valid) begin
            r_line[BEAT_W-1:0] <= fl_data;
            r_fl_index         <= fl_index;
            r_beat             <= 2'd1;
            r_state            <= F_COLL;
          end
        end
        F_COLL: begin
          if (fl_valid) begin
            r_line[{r_beat, 5'd0} +: BEAT_W] <= fl_data;
            if (r_beat == 2'd3) begin
              r_beat  <= 2'd0;
              r_state <= F_PEND;
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end
        end
        F_PEND: begin
          r_fl_done <= 1'b1;
          r_fl_way  <= w_vic;
          r_state   <= F_IDLE;
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_starve <= '0;
    end else if (ld_req && !ld_gnt) begin
      if (r_starve < SW'(STARVE_MAX)) r_starve <= r_starve + SW'(1);
    end else begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ld_rvalid <= 1'b0;
      r_ld_rdata  <= '0;
    end else begin
      r_ld_rvalid <= ld_gnt;
      if (ld_gnt) r_ld_rdata <= (|ld_way) ? ds_cache_line : '0;
    end
  end
endmodule

// File: tb/tb_ds_ctrl.sv
// Randomised and directed bench for ds_ctrl against a behavioural model of fills, arbitration,
// pseudo-LRU victims and the data store contents.
module tb_ds_ctrl;
  localparam int STARVE = 3;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         ld_req = 1'b0;
  logic [1:0]   ld_index = '0;
  logic [3:0]   ld_way = '0;
  logic         ld_gnt, ld_rvalid;
  logic [127:0] ld_rdata;
  logic         st_req = 1'b0;
  logic [1:0]   st_index = '0;
  logic [3:0]   st_way = '0;
  logic [127:0] st_data = '0;
  logic [127:0] st_mask = '0;
  logic         st_gnt;
  logic         fl_valid = 1'b0;
  logic [1:0]   fl_index = '0;
  logic [31:0]  fl_data = '0;
  logic         fl_ready, fl_done;
  logic [3:0]   fl_way;
  logic         ds_valid, ds_w;
  logic [1:0]   ds_index;
  logic [3:0]   ds_way;
  logic [127:0] ds_data_in, ds_mask_in, ds_cache_line;

  ds_ctrl #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .clr(clr),
    .ld_req(ld_req), .ld_index(ld_index), .ld_way(ld_way), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_index(st_index), .st_way(st_way), .st_data(st_data),
    .st_mask(st_mask), .st_gnt(st_gnt),
    .fl_valid(fl_valid), .fl_index(fl_index), .fl_data(fl_data), .fl_ready(fl_ready),
    .fl_done(fl_done), .fl_way(fl_way),
    .ds_valid(ds_valid), .ds_index(ds_index), .ds_way(ds_way), .ds_data_in(ds_data_in),
    .ds_mask_in(ds_mask_in), .ds_w(ds_w), .ds_cache_line(ds_cache_line)
  );

  always #5 clk = ~clk;

  // Data store as the DUT sees it, written only through the DUT's ds_* pins.
  logic [127:0] env_mem [4][4];
  always_comb begin
    ds_cache_line = '0;
    for (int w = 0; w < 4; w++) if (ds_way[w]) ds_cache_line = env_mem[ds_index][w];
  end
  always @(posedge clk) begin
    if (ds_valid && ds_w)
      for (int w = 0; w < 4; w++)
        if (ds_way[w])
          env_mem[ds_index][w] <= (env_mem[ds_index][w] & ~ds_mask_in) | (ds_data_in & ds_mask_in);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [127:0] ref_mem [4][4];
  int           ref_plru [4];
  int           m_beats, m_set, m_starve;
  bit           m_pend;
  logic [127:0] m_line;
  bit           e_rvalid, e_done;
  logic [127:0] e_rdata;
  logic [3:0]   e_flway;
  bit           last_ldg, last_stg;

  function automatic int way_pos(input logic [3:0] w);
    for (int i = 0; i < 4; i++) if (w[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] ref_victim(input int bits);
    int idx;
    idx = (bits & 1) ? 2 + ((bits >> 2) & 1) : ((bits >> 1) & 1);
    return 4'(1 << idx);
  endfunction

  // Point the tree away from the touched way; only the bits on its path move.
  function automatic int ref_touch(input int bits, input int pos);
    int b0, b1, b2;
    b0 = bits & 1; b1 = (bits >> 1) & 1; b2 = (bits >> 2) & 1;
    b0 = (pos < 2) ? 1 : 0;
    if (pos < 2) b1 = (pos == 0) ? 1 : 0;
    else         b2 = (pos == 2) ? 1 : 0;
    return b0 | (b1 << 1) | (b2 << 2);
  endfunction

  task automatic model_reset();
    m_beats = 0; m_set = 0; m_starve = 0; m_pend = 0; m_line = '0;
    e_rvalid = 0; e_done = 0; e_rdata = '0; e_flway = '0;
    last_ldg = 0; last_stg = 0;
    for (int s = 0; s < 4; s++) ref_plru[s] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    ld_req = 0; st_req = 0; fl_valid = 0;
    @(negedge clk);
    model_reset();
    chk("rst_ld_rvalid", 128'(ld_rvalid), 128'(0));
    chk("rst_ld_rdata", ld_rdata, '0);
    chk("rst_fl_done", 128'(fl_done), 128'(0));
    chk("rst_fl_way", 128'(fl_way), 128'(0));
    chk("rst_fl_ready", 128'(fl_ready), 128'(1));
    chk("rst_ds_valid", 128'(ds_valid), 128'(0));
    chk("rst_ds_w", 128'(ds_w), 128'(0));
    @(posedge clk);
    #1 clr = 1'b1;
  endtask

  // One clock: compare every output against the model at negedge, then advance the model.
  task automatic cycle();
    bit fill_w, e_ldg, e_stg, e_v, e_w;
    logic [1:0]   e_idx;
    logic [3:0]   e_way, vic;
    logic [127:0] e_data, e_mask;
    @(negedge clk);
    fill_w = m_pend;
    e_ldg  = !fill_w && ld_req && (m_starve >= STARVE || !st_req);
    e_stg  = !fill_w && st_req && !e_ldg;
    vic    = ref_victim(ref_plru[m_set]);
    e_v = 0; e_w = 0; e_idx = '0; e_way = '0; e_data = '0; e_mask = '0;
    if (fill_w) begin
      e_v = 1; e_w = 1; e_idx = 2'(m_set); e_way = vic; e_data = m_line; e_mask = '1;
    end else if (e_stg) begin
      e_v = 1; e_w = (st_way != 0); e_idx = st_index; e_way = st_way;
      e_data = st_data; e_mask = st_mask;
    end else if (e_ldg) begin
      e_v = 1; e_idx = ld_index; e_way = ld_way;
    end
    chk("ld_rvalid", 128'(ld_rvalid), 128'(e_rvalid));
    chk("ld_rdata", ld_rdata, e_rdata);
    chk("fl_done", 128'(fl_done), 128'(e_done));
    if (e_done) chk("fl_way", 128'(fl_way), 128'(e_flway));
    chk("fl_ready", 128'(fl_ready), 128'(!m_pend));
    chk("ld_gnt", 128'(ld_gnt), 128'(e_ldg));
    chk("st_gnt", 128'(st_gnt), 128'(e_stg));
    chk("ds_valid", 128'(ds_valid), 128'(e_v));
    chk("ds_w", 128'(ds_w), 128'(e_w));
    chk("ds_index", 128'(ds_index), 128'(e_idx));
    chk("ds_way", 128'(ds_way), 128'(e_way));
    chk("ds_data_in", ds_data_in, e_data);
    chk("ds_mask_in", ds_mask_in, e_mask);

    e_rvalid = e_ldg;
    if (e_ldg) e_rdata = (ld_way == 0) ? '0 : ref_mem[ld_index][way_pos(ld_way)];
    e_done = fill_w;
    if (fill_w) e_flway = vic;
    m_starve = (ld_req && !e_ldg) ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
    if (fill_w) begin
      ref_mem[m_set][way_pos(vic)] = m_line;
      ref_plru[m_set] = ref_touch(ref_plru[m_set], way_pos(vic));
    end else if (e_stg && st_way != 0) begin
      ref_mem[st_index][way_pos(st_way)] =
        (ref_mem[st_index][way_pos(st_way)] & ~st_mask) | (st_data & st_mask);
      ref_plru[st_index] = ref_touch(ref_plru[st_index], way_pos(st_way));
    end else if (e_ldg && ld_way != 0) begin
      ref_plru[ld_index] = ref_touch(ref_plru[ld_index], way_pos(ld_way));
    end
    if (fill_w) begin
      m_pend = 0;
    end else if (fl_valid) begin
      if (m_beats == 0) m_set = fl_index;
      m_line[32*m_beats +: 32] = fl_data;
      m_beats++;
      if (m_beats == 4) begin m_pend = 1; m_beats = 0; end
    end
    last_ldg = e_ldg;
    last_stg = e_stg;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rnd_way();
    int r;
    r = $urandom_range(0, 4);
    return (r == 0) ? 4'b0000 : 4'(1 << (r - 1));
  endfunction

  task automatic send_beat(input logic [1:0] idx, input logic [31:0] data);
    fl_valid = 1; fl_index = idx; fl_data = data;
    cycle();
    fl_valid = 0;
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 4; w++) begin
        env_mem[s][w] = {$urandom(), $urandom(), $urandom(), $urandom()};
        ref_mem[s][w] = env_mem[s][w];
      end
    env_mem[1][1] = {16{8'hA5}};
    ref_mem[1][1] = {16{8'hA5}};
    model_reset();
    do_reset();

    // Load hit, then store with a low-byte mask, then a full fill of set 3.
    ld_req = 1; ld_index = 2'd1; ld_way = 4'b0010;
    cycle();
    ld_req = 0;
    st_req = 1; st_index = 2'd2; st_way = 4'b0001;
    st_data = {4{32'hDEADBEEF}}; st_mask = 128'hFF;
    cycle();
    st_req = 0;
    cycle();
    send_beat(2'd3, 32'h11111111);
    send_beat(2'd0, 32'h22222222);
    send_beat(2'd0, 32'h33333333);
    send_beat(2'd0, 32'h44444444);
    chk("fill_line", ds_data_in, 128'h44444444_33333333_22222222_11111111);
    chk("fill_way", 128'(ds_way), 128'(4'b0001));
    cycle();
    cycle();
    // Load after store on the same line sees the merged data.
    ld_req = 1; ld_index = 2'd2; ld_way = 4'b0001;
    cycle();
    ld_req = 0;
    cycle();

    // Store and load held continuously: load wins once starvation saturates.
    st_req = 1; st_index = 2'd0; st_way = 4'b0100; st_mask = '1;
    ld_req = 1; ld_index = 2'd0; ld_way = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      st_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      cycle();
    end
    st_req = 0; ld_req = 0;
    cycle();

    // Store and load arrive while a fill write is pending.
    send_beat(2'd1, $urandom());
    send_beat(2'd1, $urandom());
    send_beat(2'd1, $urandom());
    send_beat(2'd1, $urandom());
    st_req = 1; st_index = 2'd1; st_way = 4'b0010; st_data = '1; st_mask = 128'hF0F0;
    ld_req = 1; ld_index = 2'd1; ld_way = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (last_stg) st_req = 0;
      if (last_ldg) ld_req = 0;
    end

    // Reset after two beats discards the partial line; the next fill starts fresh.
    send_beat(2'd2, 32'hAAAAAAAA);
    send_beat(2'd2, 32'hBBBBBBBB);
    do_reset();
    send_beat(2'd2, 32'h01010101);
    send_beat(2'd2, 32'h02020202);
    send_beat(2'd2, 32'h03030303);
    send_beat(2'd2, 32'h04040404);
    cycle();
    cycle();

    for (int i = 0; i < 3000; i++) begin
      if (!ld_req || last_ldg) begin
        ld_req = ($urandom_range(0, 99) < 55);
        ld_index = 2'($urandom_range(0, 3));
        ld_way = rnd_way();
      end
      if (!st_req || last_stg) begin
        st_req = ($urandom_range(0, 99) < 55);
        st_index = 2'($urandom_range(0, 3));
        st_way = rnd_way();
        st_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        st_mask = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      fl_valid = ($urandom_range(0, 99) < 40);
      fl_index = 2'($urandom_range(0, 3));
      fl_data = $urandom();
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
